rank_store_ctrl: RTL and testbench
==================================

Name: rank_store_ctrl

Overview:
- Controller and scheduler in front of the per-flow rank store (FLOWS circular banks of SIZE 32-bit ranks).
- Tracks per-flow occupancy and admits enqueues only to non-full flows.
- Picks the next non-empty flow round-robin on each dequeue request and sequences the store's one-cycle-latency pop.
- Sits between the packet classifier (enqueue side) and the PIFO tree (dequeue side).

Parameters:
FLOWS, 10, number of flows; must match the rank store.
SIZE, 50, entries per flow; must match the rank store.
FW, $clog2(FLOWS), derived flow-index width.
CW, $clog2(SIZE+1), derived occupancy-counter width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enq_valid  in  1  enqueue request
enq_flow  in  FW  binary flow index
enq_rank  in  32  rank to store
enq_ready  out  1  enqueue accepted when enq_valid && enq_ready at a clock edge
deq_req  in  1  request next rank
deq_ready  out  1  controller idle; deq_req is sampled only while this is high
deq_valid  out  1  one-cycle pulse: dequeued rank is valid
deq_rank  out  32  dequeued rank
deq_flow  out  FW  flow the rank came from
flow_empty  out  FLOWS  per-flow count==0
flow_full  out  FLOWS  per-flow count==SIZE
rs_push  out  1  to store push
rs_push_value  out  32  to store push_value
rs_push_flow  out  FLOWS  to store push_flow, one-hot
rs_pop  out  1  to store pop
rs_pop_flow  out  FLOWS  to store pop_flow, one-hot
rs_pop_value  in  32  from store pop_value
rs_pop_valid  in  1  from store pop_valid

Behaviour:
- Reset (rst_n low, async):
  - All counts = 0; RR pointer = 0; state = IDLE.
  - rs_push, rs_pop, deq_valid = 0; rs_*_flow = 0; deq_rank = 0; deq_flow = 0.
  - Store is reset by the same event (integrator drives store rst from !rst_n), so heads/tails realign.
- enq_ready (combinational): high iff enq_flow < FLOWS && count[enq_flow] < SIZE. An out-of-range index is never ready.
- Accepted enqueue at edge N:
  - count[enq_flow]++ at edge N.
  - During cycle N+1: rs_push = 1, rs_push_value = enq_rank, rs_push_flow = one-hot(enq_flow).
  - Back-to-back accepts give one push per cycle.
- Dequeue FSM, IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE: deq_ready = 1. If deq_req is high and any count > 0 at edge N:
    - grant flow g = first non-empty flow at or after the RR pointer (cyclic);
    - count[g]-- ; pointer = (g+1) mod FLOWS; go to ISSUE.
    - If all flows are empty, the request is dropped: no pop, stay in IDLE.
  - ISSUE (cycle N+1): rs_pop = 1, rs_pop_flow = one-hot(g); go to WAIT.
  - WAIT (cycle N+2): store returns rs_pop_valid. Capture rs_pop_value into deq_rank and g into deq_flow; go to IDLE.
  - deq_valid pulses during cycle N+3; deq_ready is high again in N+3.
  - Latency is 3 cycles; throughput is 1 dequeue per 3 cycles.
  - If rs_pop_valid is low in WAIT (protocol error), deq_valid is still not asserted; FSM returns to IDLE.
- Counts are registered; all eligibility uses pre-edge values:
  - A flow at count 0 receiving an enqueue in the same cycle is not eligible for that grant.
  - A full flow popped in the same cycle still rejects that cycle's enqueue.
  - Simultaneous accept and grant on the same flow leave the count unchanged.
- Push data is written to the store at the end of N+1; the earliest pop read of it is at the end of N+2, so the data is always present.
- Counts never exceed SIZE and never underflow; saturation is guaranteed by the enq_ready and grant rules.
- flow_empty and flow_full are combinational from the counts.

Optional Feature:
- Macro: STRICT_PRIO_EN.
- Defined: grant = lowest-index non-empty flow; the RR pointer is removed (no register).
- Undefined: round-robin as described above.
- All latencies and interfaces are identical in both builds.

Test Plan:
- Reset, then enqueue flow 2 with ranks 5 then 7:
  - rs_push pulses twice with rs_push_flow = 0b0000000100; flow_empty[2] = 0.
  - Two deq_req -> deq_valid 3 cycles after each acceptance with rank 5 then 7, deq_flow = 2; flow_empty[2] = 1.
- Round-robin: one rank in each of flows 0, 3, 7; three dequeues -> deq_flow order 0, 3, 7.
  - Then refill flows 0 and 3 -> order 0, 3 (pointer wraps from 8).
  - Under STRICT_PRIO_EN, flows 7 and 3 loaded -> order 3, 7.
- Full, with SIZE = 4: four enqueues to flow 1 accepted; flow_full[1] = 1 and enq_ready = 0 for a fifth.
  - One dequeue, then the fifth enqueue is accepted.
  - enq_flow = FLOWS -> enq_ready = 0; no push occurs.
- Empty: deq_req held high with all flows empty -> no rs_pop, deq_valid stays 0, deq_ready stays 1.
- Simultaneous: flow 4 holds count 1; enqueue to flow 4 and deq_req in the same cycle -> count stays 1; deq_rank = the older rank.
- Reset mid-op: drop rst_n during WAIT -> outputs clear immediately, no deq_valid, flow_empty all ones.
  - First post-reset enqueue and dequeue on flow 0 return the new rank.

Source files
------------

// File: rtl/rank_store_ctrl_if.sv
// Handshake and store-side bus of rank_store_ctrl: classifier enqueue, PIFO-tree dequeue,
// flow status, and the push/pop port of the per-flow rank store.
interface rank_store_ctrl_if #(
  parameter int FLOWS = 10,
  parameter int FW    = (FLOWS > 1) ? $clog2(FLOWS) : 1
);
  logic              enq_valid;
  logic [FW-1:0]     enq_flow;
  logic [31:0]       enq_rank;
  logic              enq_ready;
  logic              deq_req;
  logic              deq_ready;
  logic              deq_valid;
  logic [31:0]       deq_rank;
  logic [FW-1:0]     deq_flow;
  logic [FLOWS-1:0]  flow_empty;
  logic [FLOWS-1:0]  flow_full;
  logic              rs_push;
  logic [31:0]       rs_push_value;
  logic [FLOWS-1:0]  rs_push_flow;
  logic              rs_pop;
  logic [FLOWS-1:0]  rs_pop_flow;
  logic [31:0]       rs_pop_value;
  logic              rs_pop_valid;

  modport master (
    input  enq_valid, enq_flow, enq_rank, deq_req, rs_pop_value, rs_pop_valid,
    output enq_ready, deq_ready, deq_valid, deq_rank, deq_flow, flow_empty, flow_full,
           rs_push, rs_push_value, rs_push_flow, rs_pop, rs_pop_flow
  );

  modport slave (
    output enq_valid, enq_flow, enq_rank, deq_req, rs_pop_value, rs_pop_valid,
    input  enq_ready, deq_ready, deq_valid, deq_rank, deq_flow, flow_empty, flow_full,
           rs_push, rs_push_value, rs_push_flow, rs_pop, rs_pop_flow
  );
endinterface

// File: rtl/rank_store_ctrl.sv
// rank_store_ctrl: per-flow occupancy, enqueue admission and round-robin dequeue sequencing
// in front of the rank store. Define STRICT_PRIO_EN to grant the lowest-index non-empty flow.
module rank_store_ctrl #(
  parameter int FLOWS = 10,
  parameter int SIZE  = 50,
  parameter int FW    = (FLOWS > 1) ? $clog2(FLOWS) : 1,
  parameter int CW    = $clog2(SIZE + 1)
) (
  input logic               clk,
  input logic               rst_n,
  rank_store_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q [FLOWS];
  logic [CW-1:0]    count_d [FLOWS];
  logic [FW-1:0]    gnt_flow_q, gnt_flow_d;
  logic             push_q, push_d;
  logic [31:0]      push_value_q, push_value_d;
  logic [FLOWS-1:0] push_flow_q, push_flow_d;
  logic             pop_q, pop_d;
  logic [FLOWS-1:0] pop_flow_q, pop_flow_d;
  logic             deq_valid_q, deq_valid_d;
  logic [31:0]      deq_rank_q, deq_rank_d;
  logic [FW-1:0]    deq_flow_q, deq_flow_d;

  logic             enq_ready_s, enq_fire_s, grant_s, gnt_found_s;
  logic [FW-1:0]    gnt_idx_s, scan_start_s;
  logic [FLOWS-1:0] nonempty_s, full_s;

  function automatic logic [FLOWS-1:0] onehot(input logic [FW-1:0] idx);
    logic [FLOWS-1:0] v;
    v = '0;
    for (int f = 0; f < FLOWS; f++) begin
      v[f] = (idx == FW'(f));
    end
    return v;
  endfunction

`ifdef STRICT_PRIO_EN
  assign scan_start_s = '0;
`else
  logic [FW-1:0] ptr_q, ptr_d;

  // Round-robin pointer: one past the last granted flow, wrapping at FLOWS.
  always_comb begin
    if (grant_s) begin
      ptr_d = (gnt_idx_s == FW'(FLOWS - 1)) ? '0 : gnt_idx_s + FW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign scan_start_s = ptr_q;
`endif

  // Occupancy status and enqueue admission, all from pre-edge counts.
  always_comb begin
    enq_ready_s = 1'b0;
    for (int f = 0; f < FLOWS; f++) begin
      nonempty_s[f] = (count_q[f] != CW'(0));
      full_s[f]     = (count_q[f] == CW'(SIZE));
      enq_ready_s   = (bus.enq_flow == FW'(f)) ? !full_s[f] : enq_ready_s;
    end
    enq_fire_s = bus.enq_valid && enq_ready_s;
  end

  // Cyclic search: lowest non-empty flow at/after the start, else lowest non-empty overall.
  always_comb begin
    logic          hi_found;
    logic [FW-1:0] hi_idx, lo_idx;
    hi_found    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    gnt_found_s = 1'b0;
    for (int f = FLOWS - 1; f >= 0; f--) begin
      lo_idx      = nonempty_s[f] ? FW'(f) : lo_idx;
      gnt_found_s = gnt_found_s | nonempty_s[f];
      hi_idx      = (nonempty_s[f] && (FW'(f) >= scan_start_s)) ? FW'(f) : hi_idx;
      hi_found    = hi_found | (nonempty_s[f] && (FW'(f) >= scan_start_s));
    end
    gnt_idx_s = hi_found ? hi_idx : lo_idx;
  end

  // Dequeue sequencer: grant in IDLE, pop in ISSUE, capture the store's answer in WAIT.
  always_comb begin
    state_d     = state_q;
    grant_s     = 1'b0;
    gnt_flow_d  = gnt_flow_q;
    pop_d       = 1'b0;
    pop_flow_d  = '0;
    deq_valid_d = 1'b0;
    deq_rank_d  = deq_rank_q;
    deq_flow_d  = deq_flow_q;
    case (state_q)
      IDLE: begin
        if (bus.deq_req && gnt_found_s) begin
          grant_s    = 1'b1;
          gnt_flow_d = gnt_idx_s;
          pop_d      = 1'b1;
          pop_flow_d = onehot(gnt_idx_s);
          state_d    = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = IDLE;
        if (bus.rs_pop_valid) begin
          deq_valid_d = 1'b1;
          deq_rank_d  = bus.rs_pop_value;
          deq_flow_d  = gnt_flow_q;
        end else begin
          deq_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next counts and push staging; an accept and a grant on one flow cancel out.
  always_comb begin
    logic inc, dec;
    for (int f = 0; f < FLOWS; f++) begin
      inc = enq_fire_s && (bus.enq_flow == FW'(f));
      dec = grant_s && (gnt_idx_s == FW'(f));
      if (inc && !dec) begin
        count_d[f] = count_q[f] + CW'(1);
      end else if (dec && !inc) begin
        count_d[f] = count_q[f] - CW'(1);
      end else begin
        count_d[f] = count_q[f];
      end
    end
    push_d       = enq_fire_s;
    push_value_d = enq_fire_s ? bus.enq_rank : push_value_q;
    push_flow_d  = enq_fire_s ? onehot(bus.enq_flow) : '0;
  end

  // State, counts and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_flow_q   <= '0;
      push_q       <= 1'b0;
      push_value_q <= 32'd0;
      push_flow_q  <= '0;
      pop_q        <= 1'b0;
      pop_flow_q   <= '0;
      deq_valid_q  <= 1'b0;
      deq_rank_q   <= 32'd0;
      deq_flow_q   <= '0;
      for (int f = 0; f < FLOWS; f++) begin
        count_q[f] <= '0;
      end
    end else begin
      state_q      <= state_d;
      gnt_flow_q   <= gnt_flow_d;
      push_q       <= push_d;
      push_value_q <= push_value_d;
      push_flow_q  <= push_flow_d;
      pop_q        <= pop_d;
      pop_flow_q   <= pop_flow_d;
      deq_valid_q  <= deq_valid_d;
      deq_rank_q   <= deq_rank_d;
      deq_flow_q   <= deq_flow_d;
      for (int f = 0; f < FLOWS; f++) begin
        count_q[f] <= count_d[f];
      end
    end
  end

  assign bus.enq_ready     = enq_ready_s;
  assign bus.deq_ready     = (state_q == IDLE);
  assign bus.deq_valid     = deq_valid_q;
  assign bus.deq_rank      = deq_rank_q;
  assign bus.deq_flow      = deq_flow_q;
  assign bus.flow_empty    = ~nonempty_s;
  assign bus.flow_full     = full_s;
  assign bus.rs_push       = push_q;
  assign bus.rs_push_value = push_value_q;
  assign bus.rs_push_flow  = push_flow_q;
  assign bus.rs_pop        = pop_q;
  assign bus.rs_pop_flow   = pop_flow_q;
endmodule

// File: tb/tb_rank_store_ctrl.sv
// Scoreboard bench for rank_store_ctrl: per-flow queue reference model, behavioural rank store,
// directed scenarios followed by randomized traffic.
module tb_rank_store_ctrl;
  localparam int FLOWS = 10;
  localparam int SIZE  = 4;
  localparam int FW    = $clog2(FLOWS);

  typedef struct {
    logic [31:0] rank;
    int          flow;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  rank_store_ctrl_if #(.FLOWS(FLOWS)) bus ();

  rank_store_ctrl #(.FLOWS(FLOWS), .SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: ranks held per flow (counted from acceptance), RR pointer, dequeue busy time.
  logic [31:0] mq [FLOWS][$];
  int          rr = 0;
  int          busy = 0;
  exp_t        exp_deq[$];
  exp_t        exp_push[$];
  exp_t        mon_e;

  // Behavioural rank store: FIFO per flow, pop data returned one cycle later.
  logic [31:0] sq [FLOWS][$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < FLOWS; f++) sq[f].delete();
      bus.rs_pop_valid <= 1'b0;
      bus.rs_pop_value <= 32'd0;
    end else begin
      bus.rs_pop_valid <= 1'b0;
      if (bus.rs_pop) begin
        for (int f = 0; f < FLOWS; f++) begin
          if (bus.rs_pop_flow[f] && sq[f].size() > 0) begin
            bus.rs_pop_value <= sq[f].pop_front();
            bus.rs_pop_valid <= 1'b1;
          end
        end
      end
      if (bus.rs_push) begin
        for (int f = 0; f < FLOWS; f++) begin
          if (bus.rs_push_flow[f]) sq[f].push_back(bus.rs_push_value);
        end
      end
    end
  end

  function automatic logic [FLOWS-1:0] onehot(input int idx);
    logic [FLOWS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a push or a dequeued rank.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rs_push) begin
        if (exp_push.size() == 0) chk("push_unexpected", 64'd1, 64'd0);
        else begin
          mon_e = exp_push.pop_front();
          chk("push_value", bus.rs_push_value, mon_e.rank);
          chk("push_flow", bus.rs_push_flow, onehot(mon_e.flow));
          chk("push_cycle", cyc, mon_e.due);
        end
      end else if (exp_push.size() > 0 && exp_push[0].due <= cyc) begin
        chk("push_missing", 64'd0, 64'd1);
        void'(exp_push.pop_front());
      end
      if (bus.deq_valid) begin
        if (exp_deq.size() == 0) chk("deq_unexpected", 64'd1, 64'd0);
        else begin
          mon_e = exp_deq.pop_front();
          chk("deq_rank", bus.deq_rank, mon_e.rank);
          chk("deq_flow", bus.deq_flow, mon_e.flow);
          chk("deq_cycle", cyc, mon_e.due);
        end
      end else if (exp_deq.size() > 0 && exp_deq[0].due <= cyc) begin
        chk("deq_missing", 64'd0, 64'd1);
        void'(exp_deq.pop_front());
      end
    end
  end

  // One clock of stimulus: drive, check status against the model, then advance the model.
  task automatic step(input bit ev, input int ef, input logic [31:0] er, input bit dr);
    bit               acc, gnt;
    int               g, c, start, j;
    logic [FLOWS-1:0] emp, ful;
    exp_t             e;
    @(negedge clk);
    bus.enq_valid = ev;
    bus.enq_flow  = FW'(ef);
    bus.enq_rank  = er;
    bus.deq_req   = dr;
    #1;
    c = cyc;
    acc = (ef < FLOWS) ? (mq[ef].size() < SIZE) : 1'b0;
    for (int f = 0; f < FLOWS; f++) begin
      emp[f] = (mq[f].size() == 0);
      ful[f] = (mq[f].size() == SIZE);
    end
    chk("enq_ready", bus.enq_ready, acc);
    chk("deq_ready", bus.deq_ready, busy == 0);
    chk("rs_pop", bus.rs_pop, busy == 2);
    chk("flow_empty", bus.flow_empty, emp);
    chk("flow_full", bus.flow_full, ful);
`ifdef STRICT_PRIO_EN
    start = 0;
`else
    start = rr;
`endif
    gnt = 1'b0;
    g = 0;
    if (dr && busy == 0) begin
      for (int k = 0; k < FLOWS; k++) begin
        j = (start + k) % FLOWS;
        if (!gnt && mq[j].size() > 0) begin
          gnt = 1'b1;
          g = j;
        end
      end
    end
    @(posedge clk);
    if (gnt) begin
      e.flow = g;
      e.rank = mq[g].pop_front();
      e.due  = c + 3;
      exp_deq.push_back(e);
      rr   = (g + 1) % FLOWS;
      busy = 2;
    end else if (busy > 0) begin
      busy--;
    end
    if (ev && acc) begin
      mq[ef].push_back(er);
      e.flow = ef;
      e.rank = er;
      e.due  = c + 1;
      exp_push.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.enq_valid = 1'b0;
    bus.deq_req   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_deq_valid", bus.deq_valid, 64'd0);
    chk("rst_deq_rank", bus.deq_rank, 64'd0);
    chk("rst_deq_flow", bus.deq_flow, 64'd0);
    chk("rst_rs_push", bus.rs_push, 64'd0);
    chk("rst_rs_push_flow", bus.rs_push_flow, 64'd0);
    chk("rst_rs_pop", bus.rs_pop, 64'd0);
    chk("rst_rs_pop_flow", bus.rs_pop_flow, 64'd0);
    chk("rst_flow_empty", bus.flow_empty, {FLOWS{1'b1}});
    chk("rst_flow_full", bus.flow_full, 64'd0);
    chk("rst_deq_ready", bus.deq_ready, 64'd1);
    for (int f = 0; f < FLOWS; f++) mq[f].delete();
    exp_deq.delete();
    exp_push.delete();
    busy = 0;
    rr = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.enq_valid = 1'b0;
    bus.enq_flow  = '0;
    bus.enq_rank  = 32'd0;
    bus.deq_req   = 1'b0;
    do_reset();

    // Two ranks through flow 2 in order.
    step(1'b1, 2, 32'd5, 1'b0);
    step(1'b1, 2, 32'd7, 1'b0);
    idle(2);
    step(1'b0, 0, 32'd0, 1'b1);
    idle(3);
    step(1'b0, 0, 32'd0, 1'b1);
    idle(4);

    // Round-robin over flows 0, 3, 7, then a refill that wraps the pointer.
    do_reset();
    step(1'b1, 0, 32'd100, 1'b0);
    step(1'b1, 3, 32'd103, 1'b0);
    step(1'b1, 7, 32'd107, 1'b0);
    repeat (3) begin
      step(1'b0, 0, 32'd0, 1'b1);
      idle(2);
    end
    step(1'b1, 0, 32'd200, 1'b0);
    step(1'b1, 3, 32'd203, 1'b0);
    repeat (2) begin
      step(1'b0, 0, 32'd0, 1'b1);
      idle(2);
    end
    step(1'b1, 7, 32'd307, 1'b0);
    step(1'b1, 3, 32'd303, 1'b0);
    repeat (2) begin
      step(1'b0, 0, 32'd0, 1'b1);
      idle(2);
    end
    idle(2);

    // Full flow 1, rejection, dequeue, acceptance; out-of-range flow index.
    do_reset();
    for (int i = 0; i < SIZE; i++) step(1'b1, 1, 32'(10 + i), 1'b0);
    step(1'b1, 1, 32'd99, 1'b0);
    step(1'b0, 0, 32'd0, 1'b1);
    step(1'b1, 1, 32'd98, 1'b0);
    step(1'b1, FLOWS, 32'd97, 1'b0);
    idle(4);

    // Dequeue requests with every flow empty.
    do_reset();
    repeat (6) step(1'b0, 0, 32'd0, 1'b1);

    // Enqueue and grant on the same flow in the same cycle.
    step(1'b1, 4, 32'd11, 1'b0);
    step(1'b1, 4, 32'd22, 1'b1);
    idle(4);
    step(1'b0, 0, 32'd0, 1'b1);
    idle(4);

    // Reset while the store answer is pending, then fresh traffic on flow 0.
    step(1'b1, 5, 32'd55, 1'b0);
    step(1'b0, 0, 32'd0, 1'b1);
    step(1'b0, 0, 32'd0, 1'b0);
    do_reset();
    step(1'b1, 0, 32'd77, 1'b0);
    step(1'b0, 0, 32'd0, 1'b1);
    idle(4);

    // Randomized traffic, including out-of-range flows and requests while busy.
    repeat (1500) begin
      step($urandom_range(0, 99) < 60, int'($urandom_range(0, FLOWS)), $urandom,
           $urandom_range(0, 99) < 40);
    end
    idle(6);
    chk("deq_scoreboard_drained", exp_deq.size(), 64'd0);
    chk("push_scoreboard_drained", exp_push.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
